mem_bus_master: RTL and testbench
=================================

// Module: mem_bus_master
// PURPOSE
//  CPU-side initiator for the unified single-port instruction/data memory.
//  Alternates FETCH and EXEC phases and owns the PC. Drives word address, write enable and write data;
//  latches the fetched instruction and load data. Sits between the datapath and the memory.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC value loaded on reset
//  WAIT_LIMIT  15             max cycles to wait for mem_ready before bus error (1..255)
//  ERR_DATA    32'hDEAD_BEEF  value returned on rdata/instr after a timed-out access
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   asynchronous, active-high reset
//  dp_next_pc   in   32  next PC from datapath, sampled when EXEC completes
//  dp_req       in   1   datapath requests load/store in current EXEC phase
//  dp_we        in   1   1=store, 0=load (qualified by dp_req)
//  dp_addr      in   32  byte address of data access
//  dp_wdata     in   32  store data
//  mem_rdata    in   32  memory read data, combinational from mem_addr
//  mem_ready    in   1   memory completes current access this cycle
//  mem_addr     out  30  word address to memory
//  mem_we       out  1   memory write strobe
//  mem_wdata    out  32  memory write data
//  pc           out  32  current PC
//  instr        out  32  last fetched instruction
//  rdata        out  32  last load data
//  exec         out  1   1 in EXEC phase (datapath may present dp_*), 0 in FETCH phase
//  stall        out  1   access in progress and mem_ready low
//  misalign_err out  1   sticky: data access with dp_addr[1:0]!=0
//  bus_err      out  1   sticky: mem_ready timeout
// BEHAVIOUR
//  Reset: state=FETCH, pc=RESET_PC, instr=0, rdata=0, errors=0, wait counter=0; outputs low.
//  FETCH: mem_addr=pc[31:2], mem_we=0. When mem_ready is high: instr<=mem_rdata, go to EXEC.
//  EXEC, dp_req=0: no memory access, mem_we=0, mem_addr=pc[31:2]. Completes in 1 cycle.
//  EXEC, dp_req=1, dp_addr[1:0]==0: mem_addr=dp_addr[31:2], mem_we=dp_we, mem_wdata=dp_wdata.
//   Completes on mem_ready; for a load, rdata<=mem_rdata.
//  EXEC, misaligned dp_req: no access (mem_we=0), misalign_err<=1, rdata unchanged, completes in 1 cycle.
//  EXEC completion: pc<={dp_next_pc[31:2],2'b00}, go to FETCH. Datapath must hold dp_* stable while stall=1.
//  mem_we is combinational from state/dp_*. It remains asserted until mem_ready (one write per access).
//  Zero-wait memory (mem_ready tied 1): FETCH and EXEC each take 1 cycle; 2 cycles per instruction.
//  Wait counter: cleared at each phase entry, +1 per cycle while mem_ready=0.
//   On reaching WAIT_LIMIT: abort, bus_err<=1, ERR_DATA goes to instr (FETCH) or rdata (load). Phase completes as normal.
//  mem_ready high on the same cycle the limit is reached: the access succeeds and no error is raised.
//  stall = access active & ~mem_ready & (counter != WAIT_LIMIT).
//  Error flags clear only on rst. rst mid-access aborts immediately; a write in flight may be lost.
// CONFIGURATION
//  PERF_CNT_EN defined: adds output retired_cnt[31:0], reset 0. +1 on each EXEC completion; wraps at 2^32.
//   Also adds output wait_cnt[31:0]: +1 per cycle with stall=1, saturates at 32'hFFFF_FFFF.
//  PERF_CNT_EN undefined: neither port nor their counters exist; all other behaviour is identical.
// STRUCTURE
//  mem_bus_pkg: phase enum {FETCH, EXEC}, ERR_DATA_DEF, WORD_ADDR_W=30.
//  Sub-module mem_wait_timer: clear/count/expire counter, width $clog2(WAIT_LIMIT+1).
// TESTING
//  mem_ready=1, 3 EXECs with dp_req=0 and dp_next_pc=pc+4
//   -> pc 0,4,8,C; mem_addr alternates 0,0,1,1,2,2; exec toggles every cycle.
//  Store dp_addr=0x40, dp_wdata=0x1234, mem_ready=1
//   -> mem_addr=0x10, mem_we=1 for exactly 1 cycle, mem_wdata=0x1234.
//  Load dp_addr=0x44, mem_ready low 3 cycles then high, mem_rdata=0xCAFE
//   -> stall=1 for 3 cycles, rdata=0xCAFE, pc advances once.
//  mem_ready held 0 in FETCH -> after 15 cycles bus_err=1, instr=0xDEADBEEF, exec=1.
//  Store dp_addr=0x42 -> mem_we never asserted, misalign_err=1, pc advances.
//  rst asserted mid-load wait -> pc=0, state FETCH, mem_we=0, errors 0, same cycle (async).

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the memory bus master.
package mem_bus_pkg;

   // Bus phase: instruction fetch or execute (optional data access)
   typedef enum logic {
      FETCH = 1'b0,
      EXEC  = 1'b1
   } phase_t;

   // Default word returned when an access times out
   localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

   // Memory is word addressed: byte address bits [31:2]
   localparam int WORD_ADDR_W = 30;

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-state timer: cleared at each phase entry, counts cycles while the
// memory holds off, and flags expiry once LIMIT cycles have elapsed.
module mem_wait_timer #(
   parameter int LIMIT = 15,
   parameter int W     = $clog2(LIMIT + 1)
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic count,
   output logic expired
);

   localparam logic [W-1:0] LIMIT_W = W'(LIMIT);
   localparam logic [W-1:0] ONE_W   = W'(1);

   logic [W-1:0] cnt_r;

   // Counter: clear has priority, increment stops at the limit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r <= {W{1'b0}};
      end else if (clear) begin
         cnt_r <= {W{1'b0}};
      end else if (count && (cnt_r != LIMIT_W)) begin
         cnt_r <= cnt_r + ONE_W;
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign expired = (cnt_r == LIMIT_W);

endmodule

// File: rtl/mem_bus_master.sv
// CPU-side initiator for a unified instruction/data memory. Alternates
// FETCH and EXEC phases, owns the PC and aborts stuck accesses.
// Optional feature macro: PERF_CNT_EN adds retired_cnt and wait_cnt outputs.
module mem_bus_master
   import mem_bus_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          WAIT_LIMIT = 15,
   parameter logic [31:0] ERR_DATA   = ERR_DATA_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [31:0]            dp_next_pc,
   input  logic                   dp_req,
   input  logic                   dp_we,
   input  logic [31:0]            dp_addr,
   input  logic [31:0]            dp_wdata,
   input  logic [31:0]            mem_rdata,
   input  logic                   mem_ready,
   output logic [WORD_ADDR_W-1:0] mem_addr,
   output logic                   mem_we,
   output logic [31:0]            mem_wdata,
   output logic [31:0]            pc,
   output logic [31:0]            instr,
   output logic [31:0]            rdata,
   output logic                   exec,
   output logic                   stall,
`ifdef PERF_CNT_EN
   output logic [31:0]            retired_cnt,
   output logic [31:0]            wait_cnt,
`endif
   output logic                   misalign_err,
   output logic                   bus_err
);

   phase_t      state_r;
   phase_t      state_next_s;
   logic [31:0] pc_r;
   logic [31:0] instr_r;
   logic [31:0] rdata_r;
   logic        misalign_r;
   logic        bus_err_r;

   logic        data_req_s;
   logic        misalign_s;
   logic        data_acc_s;
   logic        access_s;
   logic        expired_s;
   logic        timeout_s;
   logic        done_s;
   logic        stall_s;

   // Decode the current phase into access / completion / abort conditions
   always_comb begin
      data_req_s = (state_r == EXEC) & dp_req;
      misalign_s = data_req_s & (dp_addr[1:0] != 2'b00);
      data_acc_s = data_req_s & ~misalign_s;
      access_s   = (state_r == FETCH) | data_acc_s;
      timeout_s  = access_s & ~mem_ready & expired_s;
      done_s     = ~access_s | mem_ready | expired_s;
      stall_s    = access_s & ~mem_ready & ~expired_s;
   end

   // A fresh count starts on the cycle after every phase completes
   mem_wait_timer #(
      .LIMIT (WAIT_LIMIT)
   ) u_wait_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (done_s),
      .count   (stall_s),
      .expired (expired_s)
   );

   // Phase state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= FETCH;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next phase: flip whenever the current phase completes
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         FETCH: begin
            if (done_s) state_next_s = EXEC;
            else        state_next_s = FETCH;
         end
         EXEC: begin
            if (done_s) state_next_s = FETCH;
            else        state_next_s = EXEC;
         end
         default: state_next_s = FETCH;
      endcase
   end

   // Bus drive: data address only for an aligned data access, PC otherwise
   always_comb begin
      mem_addr  = pc_r[31:2];
      mem_we    = 1'b0;
      mem_wdata = 32'h0000_0000;
      exec      = (state_r == EXEC);
      stall     = stall_s;
      if (data_acc_s) begin
         mem_addr  = dp_addr[31:2];
         mem_we    = dp_we;
         mem_wdata = dp_we ? dp_wdata : 32'h0000_0000;
      end else begin
         mem_addr  = pc_r[31:2];
      end
   end

   // PC, fetched instruction, load data and sticky error flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_r       <= RESET_PC;
         instr_r    <= 32'h0000_0000;
         rdata_r    <= 32'h0000_0000;
         misalign_r <= 1'b0;
         bus_err_r  <= 1'b0;
      end else begin
         if ((state_r == FETCH) && done_s) begin
            instr_r <= timeout_s ? ERR_DATA : mem_rdata;
         end
         if ((state_r == EXEC) && done_s) begin
            pc_r <= {dp_next_pc[31:2], 2'b00};
         end
         if (data_acc_s && !dp_we && done_s) begin
            rdata_r <= timeout_s ? ERR_DATA : mem_rdata;
         end
         if (misalign_s) begin
            misalign_r <= 1'b1;
         end
         if (timeout_s) begin
            bus_err_r <= 1'b1;
         end
      end
   end

   assign pc           = pc_r;
   assign instr        = instr_r;
   assign rdata        = rdata_r;
   assign misalign_err = misalign_r;
   assign bus_err      = bus_err_r;

`ifdef PERF_CNT_EN
   logic [31:0] retired_cnt_r;
   logic [31:0] wait_cnt_r;

   // Retired-instruction counter (wraps) and stall-cycle counter (saturates)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         retired_cnt_r <= 32'h0000_0000;
         wait_cnt_r    <= 32'h0000_0000;
      end else begin
         if ((state_r == EXEC) && done_s) begin
            retired_cnt_r <= retired_cnt_r + 32'h0000_0001;
         end
         if (stall_s && (wait_cnt_r != 32'hFFFF_FFFF)) begin
            wait_cnt_r <= wait_cnt_r + 32'h0000_0001;
         end
      end
   end

   assign retired_cnt = retired_cnt_r;
   assign wait_cnt    = wait_cnt_r;
`endif

endmodule

// File: tb/tb_mem_bus_master.sv
// Directed bench for mem_bus_master with a queue-based scoreboard: stimulus
// pushes expected observations and expected memory writes, a monitor on
// the falling edge pops and compares them against the DUT.
module tb_mem_bus_master;

   localparam int S_PC    = 0;
   localparam int S_ADDR  = 1;
   localparam int S_WE    = 2;
   localparam int S_INSTR = 3;
   localparam int S_RDATA = 4;
   localparam int S_EXEC  = 5;
   localparam int S_STALL = 6;
   localparam int S_MIS   = 7;
   localparam int S_BUS   = 8;
   localparam int S_WDATA = 9;

   typedef struct {
      string       name;
      int          sel;
      logic [31:0] val;
   } exp_t;

   typedef struct {
      logic [29:0] addr;
      logic [31:0] data;
   } wr_t;

   logic        clk;
   logic        rst;
   logic [31:0] dp_next_pc;
   logic        dp_req;
   logic        dp_we;
   logic [31:0] dp_addr;
   logic [31:0] dp_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic [29:0] mem_addr;
   logic        mem_we;
   logic [31:0] mem_wdata;
   logic [31:0] pc;
   logic [31:0] instr;
   logic [31:0] rdata;
   logic        exec;
   logic        stall;
   logic        misalign_err;
   logic        bus_err;
`ifdef PERF_CNT_EN
   logic [31:0] retired_cnt;
   logic [31:0] wait_cnt;
`endif

   exp_t exp_q[$];
   wr_t  wr_q[$];
   int   n_vec;
   int   n_err;

   mem_bus_master dut (
      .clk          (clk),
      .rst          (rst),
      .dp_next_pc   (dp_next_pc),
      .dp_req       (dp_req),
      .dp_we        (dp_we),
      .dp_addr      (dp_addr),
      .dp_wdata     (dp_wdata),
      .mem_rdata    (mem_rdata),
      .mem_ready    (mem_ready),
      .mem_addr     (mem_addr),
      .mem_we       (mem_we),
      .mem_wdata    (mem_wdata),
      .pc           (pc),
      .instr        (instr),
      .rdata        (rdata),
      .exec         (exec),
      .stall        (stall),
`ifdef PERF_CNT_EN
      .retired_cnt  (retired_cnt),
      .wait_cnt     (wait_cnt),
`endif
      .misalign_err (misalign_err),
      .bus_err      (bus_err)
   );

   // 10-time-unit clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] get_sig(input int sel);
      case (sel)
         S_PC:    return pc;
         S_ADDR:  return {2'b00, mem_addr};
         S_WE:    return {31'd0, mem_we};
         S_INSTR: return instr;
         S_RDATA: return rdata;
         S_EXEC:  return {31'd0, exec};
         S_STALL: return {31'd0, stall};
         S_MIS:   return {31'd0, misalign_err};
         S_BUS:   return {31'd0, bus_err};
         S_WDATA: return mem_wdata;
         default: return 32'hXXXX_XXXX;
      endcase
   endfunction

   task automatic expect_sig(input string name, input int sel, input logic [31:0] val);
      exp_t e;
      e.name = name;
      e.sel  = sel;
      e.val  = val;
      exp_q.push_back(e);
   endtask

   task automatic expect_wr(input logic [29:0] addr, input logic [31:0] data);
      wr_t w;
      w.addr = addr;
      w.data = data;
      wr_q.push_back(w);
   endtask

   // Advance to just after the next rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: drain pending observations and check any completed write
   initial begin
      exp_t        e;
      wr_t         w;
      logic [31:0] act;
      forever begin
         @(negedge clk);
         while (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = get_sig(e.sel);
            n_vec++;
            if (act !== e.val) begin
               n_err++;
               $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", e.name, act, e.val, $time);
            end
         end
         if (mem_we && mem_ready && !rst) begin
            n_vec++;
            if (wr_q.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h expected no write at %0t",
                        {2'b00, mem_addr}, mem_wdata, $time);
            end else begin
               w = wr_q.pop_front();
               if (mem_addr !== w.addr || mem_wdata !== w.data) begin
                  n_err++;
                  $display("FAIL write: got addr 0x%08h data 0x%08h expected addr 0x%08h data 0x%08h",
                           {2'b00, mem_addr}, mem_wdata, {2'b00, w.addr}, w.data);
               end
            end
         end
      end
   end

   // Directed stimulus
   initial begin
      n_vec      = 0;
      n_err      = 0;
      rst        = 1'b1;
      dp_next_pc = 32'h0;
      dp_req     = 1'b0;
      dp_we      = 1'b0;
      dp_addr    = 32'h0;
      dp_wdata   = 32'h0;
      mem_rdata  = 32'h0000_0013;
      mem_ready  = 1'b1;

      // Reset state
      step();
      expect_sig("rst_pc",    S_PC,    32'h0);
      expect_sig("rst_instr", S_INSTR, 32'h0);
      expect_sig("rst_rdata", S_RDATA, 32'h0);
      expect_sig("rst_exec",  S_EXEC,  32'h0);
      expect_sig("rst_we",    S_WE,    32'h0);
      expect_sig("rst_mis",   S_MIS,   32'h0);
      expect_sig("rst_bus",   S_BUS,   32'h0);
      step();
      rst = 1'b0;

      // Zero-wait sequential execution: 0,4,8,C
      expect_sig("seq_f0_addr", S_ADDR, 32'h0);
      expect_sig("seq_f0_exec", S_EXEC, 32'h0);
      dp_next_pc = 32'h4;
      step();
      expect_sig("seq_e0_addr",  S_ADDR,  32'h0);
      expect_sig("seq_e0_exec",  S_EXEC,  32'h1);
      expect_sig("seq_e0_pc",    S_PC,    32'h0);
      expect_sig("seq_e0_instr", S_INSTR, 32'h0000_0013);
      step();
      expect_sig("seq_f1_addr", S_ADDR, 32'h1);
      expect_sig("seq_f1_exec", S_EXEC, 32'h0);
      expect_sig("seq_f1_pc",   S_PC,   32'h4);
      dp_next_pc = 32'h8;
      step();
      expect_sig("seq_e1_addr", S_ADDR, 32'h1);
      expect_sig("seq_e1_exec", S_EXEC, 32'h1);
      step();
      expect_sig("seq_f2_addr", S_ADDR, 32'h2);
      expect_sig("seq_f2_pc",   S_PC,   32'h8);
      dp_next_pc = 32'hC;
      step();
      expect_sig("seq_e2_addr", S_ADDR, 32'h2);
      expect_sig("seq_e2_exec", S_EXEC, 32'h1);
      step();
      expect_sig("seq_f3_pc",   S_PC,   32'hC);
      expect_sig("seq_f3_addr", S_ADDR, 32'h3);

      // Aligned store to 0x40
      step();
      dp_req     = 1'b1;
      dp_we      = 1'b1;
      dp_addr    = 32'h0000_0040;
      dp_wdata   = 32'h0000_1234;
      dp_next_pc = 32'h10;
      expect_wr(30'h10, 32'h0000_1234);
      expect_sig("st_addr",  S_ADDR,  32'h10);
      expect_sig("st_we",    S_WE,    32'h1);
      expect_sig("st_wdata", S_WDATA, 32'h0000_1234);
      step();
      dp_req = 1'b0;
      dp_we  = 1'b0;
      expect_sig("st_after_we", S_WE, 32'h0);
      expect_sig("st_after_pc", S_PC, 32'h10);

      // Load from 0x44 with three wait states
      step();
      dp_req     = 1'b1;
      dp_we      = 1'b0;
      dp_addr    = 32'h0000_0044;
      dp_next_pc = 32'h14;
      mem_ready  = 1'b0;
      mem_rdata  = 32'h0;
      for (int i = 0; i < 3; i++) begin
         expect_sig("ld_stall", S_STALL, 32'h1);
         expect_sig("ld_addr",  S_ADDR,  32'h11);
         expect_sig("ld_pc",    S_PC,    32'h10);
         step();
      end
      mem_ready = 1'b1;
      mem_rdata = 32'h0000_CAFE;
      expect_sig("ld_rdy_stall", S_STALL, 32'h0);
      expect_sig("ld_rdy_exec",  S_EXEC,  32'h1);
      step();
      dp_req = 1'b0;
      expect_sig("ld_rdata", S_RDATA, 32'h0000_CAFE);
      expect_sig("ld_pc2",   S_PC,    32'h14);
      expect_sig("ld_exec2", S_EXEC,  32'h0);

      // Fetch timeout: memory never ready
      mem_ready = 1'b0;
      mem_rdata = 32'h0000_0013;
      for (int i = 0; i < 15; i++) begin
         expect_sig("to_stall", S_STALL, 32'h1);
         expect_sig("to_exec",  S_EXEC,  32'h0);
         step();
      end
      expect_sig("to_lim_stall", S_STALL, 32'h0);
      expect_sig("to_lim_bus",   S_BUS,   32'h0);
      step();
      mem_ready  = 1'b1;
      dp_next_pc = 32'h18;
      expect_sig("to_bus",   S_BUS,   32'h1);
      expect_sig("to_instr", S_INSTR, 32'hDEAD_BEEF);
      expect_sig("to_exec1", S_EXEC,  32'h1);
      step();
      expect_sig("to_pc", S_PC, 32'h18);

      // Misaligned store to 0x42: no write, sticky flag
      step();
      dp_req     = 1'b1;
      dp_we      = 1'b1;
      dp_addr    = 32'h0000_0042;
      dp_wdata   = 32'h0000_5555;
      dp_next_pc = 32'h1C;
      expect_sig("mis_we",    S_WE,    32'h0);
      expect_sig("mis_stall", S_STALL, 32'h0);
      step();
      dp_req = 1'b0;
      dp_we  = 1'b0;
      expect_sig("mis_flag", S_MIS, 32'h1);
      expect_sig("mis_pc",   S_PC,  32'h1C);

      // Ready arrives on the very cycle the limit is reached: no abort
      mem_ready = 1'b0;
      for (int i = 0; i < 15; i++) begin
         step();
      end
      mem_ready = 1'b1;
      mem_rdata = 32'h0000_0033;
      expect_sig("lim_rdy_stall", S_STALL, 32'h0);
      step();
      dp_next_pc = 32'h20;
      expect_sig("lim_rdy_instr", S_INSTR, 32'h0000_0033);
      expect_sig("lim_rdy_exec",  S_EXEC,  32'h1);
      step();
      expect_sig("lim_rdy_pc", S_PC, 32'h20);

      // Asynchronous reset in the middle of a load wait
      step();
      dp_req    = 1'b1;
      dp_we     = 1'b0;
      dp_addr   = 32'h0000_0048;
      mem_ready = 1'b0;
      step();
      #1;
      rst = 1'b1;
      #1;
      expect_sig("arst_pc",    S_PC,    32'h0);
      expect_sig("arst_exec",  S_EXEC,  32'h0);
      expect_sig("arst_we",    S_WE,    32'h0);
      expect_sig("arst_bus",   S_BUS,   32'h0);
      expect_sig("arst_mis",   S_MIS,   32'h0);
      expect_sig("arst_instr", S_INSTR, 32'h0);
      @(negedge clk);
      #1;
      dp_req = 1'b0;
      step();
      step();

      // Anything still queued was never checked
      if (exp_q.size() != 0 || wr_q.size() != 0) begin
         n_err++;
         $display("FAIL drain: got %0d obs %0d writes pending expected 0", exp_q.size(), wr_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
